// File: rtl/core_mem.sv
// Memory-access stage: EX/MEM consumer, data-bus load/store with byte lanes,
// MEM/WB register set and misaligned-address exception reporting.
module core_mem (
  input  logic        clk,
  input  logic        rest,
  input  logic        em_valid,
  output logic        em_ready,
  input  logic [31:0] em_reg_data_mem_addr,
  input  logic [31:0] em_csr_data_mem_data,
  input  logic        em_mem_read,
  input  logic        em_mem_write,
  input  logic [2:0]  em_mem_op,
  input  logic [4:0]  em_rd,
  input  logic        em_reg_write,
  input  logic [11:0] em_csr,
  input  logic        em_csr_write,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rdata_valid,
  output logic        mw_valid,
  output logic [4:0]  mw_rd,
  output logic        mw_reg_write,
  output logic [31:0] mw_reg_write_data,
  output logic        mw_mem_read_data_valid,
  output logic [11:0] mw_csr,
  output logic        mw_csr_write,
  output logic [31:0] mw_csr_data,
  output logic        exc_valid,
  output logic [31:0] exc_cause,
  output logic [31:0] exc_tval
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t      state;
  state_t      state_nx;
  logic        accept;
  logic        is_mem;
  logic        mis;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] addr;

  assign addr   = em_reg_data_mem_addr;
  assign accept = em_valid && em_ready;
  assign is_mem = em_mem_read || em_mem_write;

  // op[1:0]==01 covers H/HU, 10 covers W
  assign mis = is_mem &&
    ((em_mem_op[1:0] == 2'b01 && addr[0]) ||
     (em_mem_op[1:0] == 2'b10 && addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept && is_mem && !mis) state_nx = REQ;
      REQ:  if (bus_ready) state_nx = bus_write ? IDLE : RSP;
      RSP:  if (bus_rdata_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    em_ready = (state == IDLE) && !rest;
  end

  always_comb begin
    st_wdata = 32'h0;
    st_be    = 4'b1111;
    if (em_mem_write) begin
      unique case (em_mem_op[1:0])
        2'b00: begin
          st_wdata = {4{em_csr_data_mem_data[7:0]}};
          st_be    = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          st_wdata = {2{em_csr_data_mem_data[15:0]}};
          st_be    = 4'b0011 << addr[1:0];
        end
        default: begin
          st_wdata = em_csr_data_mem_data;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    ld_b    = bus_rdata[{lo_q, 3'b000} +: 8];
    ld_h    = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    ld_data = bus_rdata;
    unique case (op_q)
      3'd0:    ld_data = {{24{ld_b[7]}}, ld_b};
      3'd1:    ld_data = {{16{ld_h[15]}}, ld_h};
      3'd4:    ld_data = {24'h0, ld_b};
      3'd5:    ld_data = {16'h0, ld_h};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      op_q                   <= '0;
      lo_q                   <= '0;
      bus_valid              <= 1'b0;
      bus_write              <= 1'b0;
      bus_addr               <= '0;
      bus_wdata              <= '0;
      bus_byte_en            <= '0;
      mw_valid               <= 1'b0;
      mw_rd                  <= '0;
      mw_reg_write           <= 1'b0;
      mw_reg_write_data      <= '0;
      mw_mem_read_data_valid <= 1'b0;
      mw_csr                 <= '0;
      mw_csr_write           <= 1'b0;
      mw_csr_data            <= '0;
      exc_valid              <= 1'b0;
      exc_cause              <= '0;
      exc_tval               <= '0;
    end else begin
      mw_valid  <= 1'b0;
      exc_valid <= 1'b0;
      if (accept) begin
        mw_rd                  <= em_rd;
        mw_reg_write           <= em_reg_write;
        mw_csr                 <= em_csr;
        mw_csr_write           <= em_csr_write;
        mw_csr_data            <= em_csr_data_mem_data;
        mw_reg_write_data      <= addr;
        mw_mem_read_data_valid <= !em_mem_read;
        op_q                   <= em_mem_op;
        lo_q                   <= addr[1:0];
        if (mis) begin
          exc_valid              <= 1'b1;
          exc_cause              <= em_mem_write ? 32'd6 : 32'd4;
          exc_tval               <= addr;
          mw_reg_write           <= 1'b0;
          mw_csr_write           <= 1'b0;
          mw_mem_read_data_valid <= 1'b1;
        end else if (is_mem) begin
          bus_valid   <= 1'b1;
          bus_write   <= em_mem_write;
          bus_addr    <= {addr[31:2], 2'b00};
          bus_wdata   <= st_wdata;
          bus_byte_en <= st_be;
        end else begin
          mw_valid <= 1'b1;
        end
      end
      if (state == REQ && bus_ready) begin
        bus_valid <= 1'b0;
        if (bus_write) mw_valid <= 1'b1;
      end
      if (state == RSP && bus_rdata_valid) begin
        mw_reg_write_data      <= ld_data;
        mw_mem_read_data_valid <= 1'b1;
        mw_valid               <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_core_mem.sv
// Bench for core_mem: scoreboard of expected retirements plus
// directed bus/exception/reset checks.
module tb_core_mem;

  logic        clk = 1'b0;
  logic        rest;
  logic        em_valid;
  logic        em_ready;
  logic [31:0] em_reg_data_mem_addr;
  logic [31:0] em_csr_data_mem_data;
  logic        em_mem_read;
  logic        em_mem_write;
  logic [2:0]  em_mem_op;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byte_en;
  logic [31:0] bus_rdata;
  logic        bus_rdata_valid;
  logic        mw_valid;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic [31:0] mw_reg_write_data;
  logic        mw_mem_read_data_valid;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic [31:0] mw_csr_data;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_tval;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  core_mem dut (
    .clk                    (clk),
    .rest                   (rest),
    .em_valid               (em_valid),
    .em_ready               (em_ready),
    .em_reg_data_mem_addr   (em_reg_data_mem_addr),
    .em_csr_data_mem_data   (em_csr_data_mem_data),
    .em_mem_read            (em_mem_read),
    .em_mem_write           (em_mem_write),
    .em_mem_op              (em_mem_op),
    .em_rd                  (em_rd),
    .em_reg_write           (em_reg_write),
    .em_csr                 (em_csr),
    .em_csr_write           (em_csr_write),
    .bus_valid              (bus_valid),
    .bus_ready              (bus_ready),
    .bus_write              (bus_write),
    .bus_addr               (bus_addr),
    .bus_wdata              (bus_wdata),
    .bus_byte_en            (bus_byte_en),
    .bus_rdata              (bus_rdata),
    .bus_rdata_valid        (bus_rdata_valid),
    .mw_valid               (mw_valid),
    .mw_rd                  (mw_rd),
    .mw_reg_write           (mw_reg_write),
    .mw_reg_write_data      (mw_reg_write_data),
    .mw_mem_read_data_valid (mw_mem_read_data_valid),
    .mw_csr                 (mw_csr),
    .mw_csr_write           (mw_csr_write),
    .mw_csr_data            (mw_csr_data),
    .exc_valid              (exc_valid),
    .exc_cause              (exc_cause),
    .exc_tval               (exc_tval)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rest === 1'b0 && mw_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("mw_unexp", {31'h0, mw_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("mw_rd", {27'h0, mw_rd}, {27'h0, e.rd});
        check("mw_rw", {31'h0, mw_reg_write}, {31'h0, e.rw});
        check("mw_mrdv", {31'h0, mw_mem_read_data_valid}, 32'h1);
        if (e.chk_data)
          check("mw_data", mw_reg_write_data, e.data);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic rd_op, input logic wr_op,
                       input logic [2:0] op, input logic [4:0] rd,
                       input logic rw, input logic [11:0] csr,
                       input logic cw);
    int n;
    em_valid             = 1'b1;
    em_reg_data_mem_addr = a;
    em_csr_data_mem_data = d;
    em_mem_read          = rd_op;
    em_mem_write         = wr_op;
    em_mem_op            = op;
    em_rd                = rd;
    em_reg_write         = rw;
    em_csr               = csr;
    em_csr_write         = cw;
    n = 0;
    while (!em_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!em_ready) check("em_ready_to", {31'h0, em_ready}, 32'h1);
    @(negedge clk);
    em_valid     = 1'b0;
    em_mem_read  = 1'b0;
    em_mem_write = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] op,
                         input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp);
    sb.push_back('{rd, 1'b1, exp, 1'b1});
    issue(a, 32'h0, 1'b1, 1'b0, op, rd, 1'b1, 12'h0, 1'b0);
    check("ld_bv", {31'h0, bus_valid}, 32'h1);
    check("ld_bw", {31'h0, bus_write}, 32'h0);
    check("ld_be", {28'h0, bus_byte_en}, 32'hF);
    check("ld_addr", bus_addr, {a[31:2], 2'b00});
    check("ld_rd_early", {27'h0, mw_rd}, {27'h0, rd});
    check("ld_mrdv0", {31'h0, mw_mem_read_data_valid}, 32'h0);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    check("ld_bv_done", {31'h0, bus_valid}, 32'h0);
    check("ld_rdy_rsp", {31'h0, em_ready}, 32'h0);
    bus_rdata_valid = 1'b1;
    bus_rdata       = 32'hDEAD_BEEF;
    bus_rdata_valid = 1'b0;
    @(negedge clk);
    check("ld_mrdv_wait", {31'h0, mw_mem_read_data_valid}, 32'h0);
    bus_rdata       = rdata;
    bus_rdata_valid = 1'b1;
    @(negedge clk);
    bus_rdata_valid = 1'b0;
    check("ld_rdy_after", {31'h0, em_ready}, 32'h1);
    check("ld_mrdv1", {31'h0, mw_mem_read_data_valid}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rest = 1'b1;
    em_valid = 1'b0;
    em_reg_data_mem_addr = '0;
    em_csr_data_mem_data = '0;
    em_mem_read = 1'b0;
    em_mem_write = 1'b0;
    em_mem_op = '0;
    em_rd = '0;
    em_reg_write = 1'b0;
    em_csr = '0;
    em_csr_write = 1'b0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    bus_rdata_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, em_ready}, 32'h0);
    check("rst_bv", {31'h0, bus_valid}, 32'h0);
    check("rst_mwv", {31'h0, mw_valid}, 32'h0);
    check("rst_exc", {31'h0, exc_valid}, 32'h0);
    check("rst_mwd", mw_reg_write_data, 32'h0);
    rest = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'h0, em_ready}, 32'h1);

    sb.push_back('{5'd5, 1'b1, 32'h1234_5678, 1'b1});
    issue(32'h1234_5678, 32'hDEAD_0001, 1'b0, 1'b0, 3'd0, 5'd5,
          1'b1, 12'h300, 1'b1);
    check("alu_csr", {20'h0, mw_csr}, 32'h300);
    check("alu_csr_we", {31'h0, mw_csr_write}, 32'h1);
    check("alu_csr_d", mw_csr_data, 32'hDEAD_0001);
    sb.push_back('{5'd9, 1'b1, 32'hCAFE_F00D, 1'b1});
    issue(32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 3'd0, 5'd9,
          1'b1, 12'h0, 1'b0);
    @(negedge clk);

    sb.push_back('{5'd0, 1'b0, 32'h0, 1'b0});
    issue(32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b1, 3'd0, 5'd0,
          1'b0, 12'h0, 1'b0);
    check("sb_bv", {31'h0, bus_valid}, 32'h1);
    check("sb_bw", {31'h0, bus_write}, 32'h1);
    check("sb_addr", bus_addr, 32'h0000_1000);
    check("sb_be", {28'h0, bus_byte_en}, 32'h8);
    check("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    check("sb_rdy", {31'h0, em_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sb_hold_bv", {31'h0, bus_valid}, 32'h1);
      check("sb_hold_addr", bus_addr, 32'h0000_1000);
      check("sb_hold_wd", bus_wdata, 32'hA5A5_A5A5);
      check("sb_hold_be", {28'h0, bus_byte_en}, 32'h8);
      check("sb_hold_rdy", {31'h0, em_ready}, 32'h0);
    end
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    check("sb_done_bv", {31'h0, bus_valid}, 32'h0);
    check("sb_done_rdy", {31'h0, em_ready}, 32'h1);

    sb.push_back('{5'd0, 1'b0, 32'h0, 1'b0});
    issue(32'h0000_1002, 32'h1234_BEEF, 1'b0, 1'b1, 3'd1, 5'd0,
          1'b0, 12'h0, 1'b0);
    check("sh_be", {28'h0, bus_byte_en}, 32'hC);
    check("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
    check("sh_addr", bus_addr, 32'h0000_1000);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;

    sb.push_back('{5'd0, 1'b0, 32'h0, 1'b0});
    issue(32'h0000_1008, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd2, 5'd0,
          1'b0, 12'h0, 1'b0);
    check("sw_be", {28'h0, bus_byte_en}, 32'hF);
    check("sw_wdata", bus_wdata, 32'h0BAD_F00D);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;

    do_load(32'h0000_2002, 3'd0, 5'd7, 32'h0080_0000, 32'hFFFF_FF80);
    do_load(32'h0000_2002, 3'd4, 5'd8, 32'h0080_0000, 32'h0000_0080);
    do_load(32'h0000_2002, 3'd5, 5'd10, 32'h8001_0000, 32'h0000_8001);
    do_load(32'h0000_2000, 3'd1, 5'd11, 32'h0000_8001, 32'hFFFF_8001);
    do_load(32'h0000_2004, 3'd2, 5'd12, 32'h89AB_CDEF, 32'h89AB_CDEF);
    do_load(32'h0000_2001, 3'd4, 5'd13, 32'h0000_7F00, 32'h0000_007F);

    issue(32'h0000_3002, 32'h0, 1'b1, 1'b0, 3'd2, 5'd3,
          1'b1, 12'h0, 1'b0);
    check("mis_ld_exc", {31'h0, exc_valid}, 32'h1);
    check("mis_ld_cause", exc_cause, 32'd4);
    check("mis_ld_tval", exc_tval, 32'h0000_3002);
    check("mis_ld_bv", {31'h0, bus_valid}, 32'h0);
    check("mis_ld_rdy", {31'h0, em_ready}, 32'h1);
    check("mis_ld_rw", {31'h0, mw_reg_write}, 32'h0);
    @(negedge clk);
    check("mis_ld_pulse", {31'h0, exc_valid}, 32'h0);

    issue(32'h0000_3001, 32'h0, 1'b0, 1'b1, 3'd1, 5'd0,
          1'b0, 12'h0, 1'b0);
    check("mis_st_exc", {31'h0, exc_valid}, 32'h1);
    check("mis_st_cause", exc_cause, 32'd6);
    check("mis_st_tval", exc_tval, 32'h0000_3001);
    check("mis_st_bv", {31'h0, bus_valid}, 32'h0);

    bus_rdata_valid = 1'b1;
    @(negedge clk);
    bus_rdata_valid = 1'b0;
    @(negedge clk);

    issue(32'h0000_3000, 32'h0, 1'b1, 1'b0, 3'd2, 5'd14,
          1'b1, 12'h0, 1'b0);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    rest = 1'b1;
    @(negedge clk);
    check("rsp_rst_rdy", {31'h0, em_ready}, 32'h0);
    check("rsp_rst_bv", {31'h0, bus_valid}, 32'h0);
    check("rsp_rst_rd", {27'h0, mw_rd}, 32'h0);
    check("rsp_rst_rw", {31'h0, mw_reg_write}, 32'h0);
    check("rsp_rst_data", mw_reg_write_data, 32'h0);
    rest = 1'b0;
    bus_rdata = 32'h1111_2222;
    bus_rdata_valid = 1'b1;
    @(negedge clk);
    bus_rdata_valid = 1'b0;
    check("stray_mwv", {31'h0, mw_valid}, 32'h0);
    check("stray_rdy", {31'h0, em_ready}, 32'h1);
    @(negedge clk);
    check("stray_mwv2", {31'h0, mw_valid}, 32'h0);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
